// File: rtl/loader_pkg.sv
// Shared types and protocol constants for the UART program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_SEND,
    ST_RUN
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: restarts from CYCLES on clear, counts down while enabled,
// and flags expiry once it has reached zero.
module loader_timeout #(
  parameter int unsigned CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = W'(CYCLES);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= W'(CYCLES);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over the UART, writes it into instruction
// memory, answers ACK/NAK and releases the core only after a verified image.
module uart_boot_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_flag,
  input  logic [7:0]        rx_data,
  input  logic              parity_error,
  output logic              rx_data_clf,
  input  logic              tx_busy,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  input  logic              boot_req
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  loader_state_t state_q, state_d;

  logic              rx_data_clf_q, rx_data_clf_d;
  logic              tx_send_q, tx_send_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              load_done_q, load_done_d;
  logic [15:0]       count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        resp_q, resp_d;

  logic        take;
  logic        in_frame;
  logic        tmo_expired;
  logic [15:0] new_count;
  logic        count_too_big;
  logic [31:0] shifted_word;

  // The flag is still high in the cycle the clear pulse is out, so skip it then.
  assign take          = rx_flag && !rx_data_clf_q;
  assign in_frame      = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                         (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign new_count     = {count_q[15:8], rx_data};
  assign count_too_big = 32'(new_count) > MAX_WORDS;
  assign shifted_word  = {rx_data, word_q[31:8]};

  loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (!in_frame || take),
    .en      (in_frame),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: begin
        if (take && !parity_error && (rx_data == SYNC_BYTE)) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (take) state_d = parity_error ? ST_SEND : ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (take) begin
          if (parity_error || count_too_big) state_d = ST_SEND;
          else if (new_count == 16'd0)       state_d = ST_CSUM;
          else                               state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (take) begin
          if (parity_error) state_d = ST_SEND;
          else if ((byte_idx_q == 2'd3) && (count_q == 16'd1)) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (take) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) state_d = (resp_q == ACK_BYTE) ? ST_RUN : ST_SYNC;
      end
      ST_RUN: begin
        if (boot_req) state_d = ST_SYNC;
      end
      default: state_d = ST_SYNC;
    endcase
    if (in_frame && !take && tmo_expired) state_d = ST_SYNC;
  end

  always_comb begin
    rx_data_clf_d = take;
    tx_send_d     = 1'b0;
    tx_data_d     = tx_data_q;
    imem_we_d     = 1'b0;
    addr_d        = imem_we_q ? (addr_q + ADDR_W'(1)) : addr_q;
    wdata_d       = wdata_q;
    core_rst_n_d  = (state_q == ST_RUN) && !boot_req;
    load_done_d   = (state_q == ST_RUN) && !boot_req;
    count_d       = count_q;
    word_d        = word_q;
    byte_idx_d    = byte_idx_q;
    sum_d         = sum_q;
    resp_d        = resp_q;
    case (state_q)
      ST_SYNC: begin
        addr_d     = '0;
        count_d    = '0;
        sum_d      = '0;
        byte_idx_d = '0;
        word_d     = '0;
      end
      ST_LEN_HI: begin
        if (take) begin
          count_d[15:8] = rx_data;
          if (parity_error) resp_d = NAK_BYTE;
        end
      end
      ST_LEN_LO: begin
        if (take) begin
          count_d = new_count;
          if (parity_error || count_too_big) resp_d = NAK_BYTE;
        end
      end
      ST_DATA: begin
        if (take) begin
          if (parity_error) begin
            resp_d = NAK_BYTE;
          end else begin
            word_d     = shifted_word;
            sum_d      = sum_q + rx_data;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              imem_we_d = 1'b1;
              wdata_d   = shifted_word;
              count_d   = count_q - 16'd1;
            end
          end
        end
      end
      ST_CSUM: begin
        if (take) resp_d = (!parity_error && (rx_data == sum_q)) ? ACK_BYTE : NAK_BYTE;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_send_d = 1'b1;
          tx_data_d = resp_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_clf_q <= 1'b0;
      tx_send_q     <= 1'b0;
      tx_data_q     <= 8'h00;
      imem_we_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      core_rst_n_q  <= 1'b0;
      load_done_q   <= 1'b0;
      count_q       <= '0;
      word_q        <= '0;
      byte_idx_q    <= '0;
      sum_q         <= '0;
      resp_q        <= '0;
    end else begin
      rx_data_clf_q <= rx_data_clf_d;
      tx_send_q     <= tx_send_d;
      tx_data_q     <= tx_data_d;
      imem_we_q     <= imem_we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      core_rst_n_q  <= core_rst_n_d;
      load_done_q   <= load_done_d;
      count_q       <= count_d;
      word_q        <= word_d;
      byte_idx_q    <= byte_idx_d;
      sum_q         <= sum_d;
      resp_q        <= resp_d;
    end
  end

  assign rx_data_clf = rx_data_clf_q;
  assign tx_send     = tx_send_q;
  assign tx_data     = tx_data_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign core_rst_n  = core_rst_n_q;
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Drives framed images into uart_boot_loader and scoreboards memory writes and
// ACK/NAK replies against a frame-level reference model.
module tb_uart_boot_loader;

  localparam int ADDR_W = 10;
  localparam int TMO    = 300;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx_flag = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              parity_error = 1'b0;
  logic              tx_busy = 1'b0;
  logic              boot_req = 1'b0;
  logic              rx_data_clf;
  logic              tx_send;
  logic [7:0]        tx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              load_done;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [7:0] d;
    bit         p;
  } rx_t;

  wr_t        expWr[$];
  logic [7:0] expTx[$];
  rx_t        frame[$];
  int         errors = 0;
  int         checks = 0;

  uart_boot_loader #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_flag      (rx_flag),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .rx_data_clf  (rx_data_clf),
    .tx_busy      (tx_busy),
    .tx_send      (tx_send),
    .tx_data      (tx_data),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst_n   (core_rst_n),
    .load_done    (load_done),
    .boot_req     (boot_req)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic boundFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Frame-level model: parses the byte stream by the protocol rules alone.
  task automatic modelFrame(output bit ack, output bit complete);
    int i;
    int n;
    logic [7:0] sum;
    logic [31:0] word;
    ack = 0;
    complete = 0;
    i = 0;
    while (i < frame.size() && !(frame[i].d == 8'hA5 && !frame[i].p)) i++;
    if (i >= frame.size()) return;
    i++;
    if (i >= frame.size()) return;
    if (frame[i].p) begin expTx.push_back(NAK); complete = 1; return; end
    n = int'(frame[i].d) * 256;
    i++;
    if (i >= frame.size()) return;
    if (frame[i].p) begin expTx.push_back(NAK); complete = 1; return; end
    n = n + int'(frame[i].d);
    i++;
    if (n > (1 << ADDR_W)) begin expTx.push_back(NAK); complete = 1; return; end
    sum = 8'h00;
    for (int w = 0; w < n; w++) begin
      word = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (i >= frame.size()) return;
        if (frame[i].p) begin expTx.push_back(NAK); complete = 1; return; end
        word = word | (32'(frame[i].d) << (8 * b));
        sum = sum + frame[i].d;
        i++;
      end
      expWr.push_back('{addr: ADDR_W'(w), data: word});
    end
    if (i >= frame.size()) return;
    complete = 1;
    ack = !frame[i].p && (frame[i].d == sum);
    expTx.push_back(ack ? ACK : NAK);
  endtask

  task automatic pushByte(input logic [7:0] d, input bit p);
    frame.push_back('{d: d, p: p});
  endtask

  // Emulates the UART receiver: flag held until the edge after the clear pulse.
  task automatic sendByte(input logic [7:0] d, input bit p);
    bit got;
    @(negedge clk);
    rx_data = d;
    parity_error = p;
    rx_flag = 1'b1;
    got = 0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk);
      #1;
      if (rx_data_clf) begin got = 1; break; end
    end
    if (!got) boundFail("rx_consume");
    @(posedge clk);
    #1;
    rx_flag = 1'b0;
    parity_error = 1'b0;
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  task automatic applyStimulus();
    bit ack, complete, done;
    modelFrame(ack, complete);
    foreach (frame[i]) sendByte(frame[i].d, frame[i].p);
    if (complete) begin
      done = 0;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        if (expTx.size() == 0) begin done = 1; break; end
      end
      if (!done) begin boundFail("tx_response"); expTx.delete(); end
      repeat (3) @(negedge clk);
      checkOutput("writes_drained", 32'(expWr.size()), 32'd0);
      checkOutput("core_rst_n_after", 32'(core_rst_n), 32'(ack));
      checkOutput("load_done_after", 32'(load_done), 32'(ack));
      if (ack) begin
        @(negedge clk);
        boot_req = 1'b1;
        @(negedge clk);
        checkOutput("boot_req_core_rst_n", 32'(core_rst_n), 32'd0);
        checkOutput("boot_req_load_done", 32'(load_done), 32'd0);
        boot_req = 1'b0;
      end
    end
  endtask

  task automatic loadImageA(input logic [7:0] csum);
    logic [7:0] img[11] = '{8'hA5, 8'h00, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00};
    frame.delete();
    foreach (img[i]) pushByte(img[i], 1'b0);
    pushByte(csum, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      tx_busy = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes memory or transmits.
  initial begin : monitor
    bit         pendRel;
    logic       expRel;
    wr_t        e;
    logic [7:0] t;
    pendRel = 0;
    expRel = 0;
    forever begin
      @(negedge clk);
      if (pendRel) begin
        checkOutput("release_core_rst_n", 32'(core_rst_n), 32'(expRel));
        checkOutput("release_load_done", 32'(load_done), 32'(expRel));
        pendRel = 0;
      end
      if (imem_we) begin
        if (expWr.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", imem_addr, imem_wdata);
        end else begin
          e = expWr.pop_front();
          checkOutput("imem_addr", 32'(imem_addr), 32'(e.addr));
          checkOutput("imem_wdata", imem_wdata, e.data);
        end
      end
      if (tx_send) begin
        if (expTx.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_tx: got 0x%0h, required no send", tx_data);
        end else begin
          t = expTx.pop_front();
          checkOutput("tx_data", 32'(tx_data), 32'(t));
          checkOutput("core_held_at_send", 32'(core_rst_n), 32'd0);
          pendRel = 1;
          expRel = (t == ACK);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int junk, n, pos;
    logic [7:0] d, sum;
    bit bad;

    repeat (3) @(negedge clk);
    checkOutput("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    checkOutput("rst_load_done", 32'(load_done), 32'd0);
    checkOutput("rst_rx_data_clf", 32'(rx_data_clf), 32'd0);
    checkOutput("rst_tx_send", 32'(tx_send), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] good image A");
    loadImageA(8'hB6);
    applyStimulus();

    $display("[TB] image A with bad checksum");
    loadImageA(8'hB7);
    applyStimulus();

    $display("[TB] junk then zero-length image");
    frame.delete();
    pushByte(8'h00, 0); pushByte(8'hFF, 0); pushByte(8'hA5, 0);
    pushByte(8'h00, 0); pushByte(8'h00, 0); pushByte(8'h00, 0);
    applyStimulus();

    $display("[TB] oversize count");
    frame.delete();
    pushByte(8'hA5, 0); pushByte(8'h04, 0); pushByte(8'h01, 0);
    applyStimulus();

    $display("[TB] timeout mid-frame");
    frame.delete();
    pushByte(8'hA5, 0); pushByte(8'h00, 0); pushByte(8'h01, 0); pushByte(8'h13, 0);
    applyStimulus();
    repeat (TMO + 100) @(negedge clk);
    checkOutput("timeout_core_rst_n", 32'(core_rst_n), 32'd0);
    loadImageA(8'hB6);
    applyStimulus();

    $display("[TB] random frames");
    for (int t = 0; t < 8; t++) begin
      frame.delete();
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        d = 8'($urandom_range(0, 255));
        if (d == 8'hA5) d = 8'h00;
        pushByte(d, $urandom_range(0, 3) == 0);
      end
      n = $urandom_range(1, 6);
      pushByte(8'hA5, 0);
      pushByte(8'(n >> 8), 0);
      pushByte(8'(n), 0);
      sum = 8'h00;
      for (int b = 0; b < 4 * n; b++) begin
        d = 8'($urandom_range(0, 255));
        pushByte(d, 0);
        sum = sum + d;
      end
      bad = ($urandom_range(0, 3) == 0);
      pushByte(bad ? sum + 8'($urandom_range(1, 255)) : sum, 0);
      if ($urandom_range(0, 4) == 0) begin
        pos = junk + 1 + $urandom_range(0, frame.size() - junk - 2);
        frame[pos].p = 1;
        while (frame.size() > pos + 1) void'(frame.pop_back());
      end
      applyStimulus();
    end

    $display("[TB] reset mid-data");
    frame.delete();
    pushByte(8'hA5, 0); pushByte(8'h00, 0); pushByte(8'h02, 0);
    pushByte(8'h13, 0); pushByte(8'h00, 0); pushByte(8'h00, 0);
    pushByte(8'h00, 0); pushByte(8'h93, 0);
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("addr_before_reset", 32'(imem_addr), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("async_imem_wdata", imem_wdata, 32'd0);
    checkOutput("async_core_rst_n", 32'(core_rst_n), 32'd0);
    checkOutput("async_tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expWr.delete();
    expTx.delete();
    repeat (2) @(negedge clk);
    loadImageA(8'hB6);
    applyStimulus();

    repeat (5) @(negedge clk);
    checkOutput("final_tx_drained", 32'(expTx.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
